// File: rtl/gpr_read_sched_pkg.sv
// Shared types and width helpers for the GPR read scheduler.
// Optional feature macro used by this slice: GPR_SCHED_R0_ZERO_EN.
package gpr_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD3   = 2'd1,
        CAP12 = 2'd2,
        CAP3  = 2'd3
    } sched_state_e;

    function automatic int widW(input int numWarps);
        return (numWarps > 1) ? $clog2(numWarps) : 1;
    endfunction

    function automatic int nrW(input int numRegs);
        return $clog2(numRegs);
    endfunction

    function automatic int dataW(input int numThreads);
        return numThreads * 32;
    endfunction

endpackage

// File: rtl/gpr_read_sched_if.sv
// Request, register-file and response signals of the GPR read scheduler.
// The slave modport is the scheduler's view; master is the surrounding pipeline.
interface gpr_read_sched_if #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_REGS    = 32,
    parameter int NUM_THREADS = 4,
    parameter int TAG_W       = 8
);
    import gpr_sched_pkg::*;

    localparam int WID_W  = widW(NUM_WARPS);
    localparam int NR_W   = nrW(NUM_REGS);
    localparam int DATA_W = dataW(NUM_THREADS);

    logic              req_valid;
    logic              req_ready;
    logic [WID_W-1:0]  req_wid;
    logic [NR_W-1:0]   req_rs1;
    logic [NR_W-1:0]   req_rs2;
    logic [NR_W-1:0]   req_rs3;
    logic              req_use_rs3;
    logic [TAG_W-1:0]  req_tag;

    logic              gpr_rd_en;
    logic [WID_W-1:0]  gpr_wid;
    logic [NR_W-1:0]   gpr_addr0;
    logic [NR_W-1:0]   gpr_addr1;
    logic [DATA_W-1:0] gpr_data0;
    logic [DATA_W-1:0] gpr_data1;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [TAG_W-1:0]  rsp_tag;
    logic [DATA_W-1:0] rsp_data1;
    logic [DATA_W-1:0] rsp_data2;
    logic [DATA_W-1:0] rsp_data3;

    modport slave (
        input  req_valid, req_wid, req_rs1, req_rs2, req_rs3, req_use_rs3, req_tag,
        output req_ready,
        output gpr_rd_en, gpr_wid, gpr_addr0, gpr_addr1,
        input  gpr_data0, gpr_data1,
        output rsp_valid, rsp_tag, rsp_data1, rsp_data2, rsp_data3,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_wid, req_rs1, req_rs2, req_rs3, req_use_rs3, req_tag,
        input  req_ready,
        input  gpr_rd_en, gpr_wid, gpr_addr0, gpr_addr1,
        output gpr_data0, gpr_data1,
        input  rsp_valid, rsp_tag, rsp_data1, rsp_data2, rsp_data3,
        output rsp_ready
    );

endinterface

// File: rtl/gpr_read_sched.sv
// Serializes one operand-read request onto a two-port register file and returns a registered response.
// GPR_SCHED_R0_ZERO_EN: when defined, operands sourced from register 0 read back as zero.
module gpr_read_sched
    import gpr_sched_pkg::*;
#(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_REGS    = 32,
    parameter int NUM_THREADS = 4,
    parameter int TAG_W       = 8
) (
    input logic              clk,
    input logic              reset,
    gpr_read_sched_if.slave  bus
);

    localparam int WID_W  = widW(NUM_WARPS);
    localparam int NR_W   = nrW(NUM_REGS);
    localparam int DATA_W = dataW(NUM_THREADS);

    sched_state_e      state_q, state_d;
    logic [WID_W-1:0]  latchWid_q, latchWid_d;
    logic [NR_W-1:0]   latchRs3_q, latchRs3_d;
    logic [TAG_W-1:0]  latchTag_q, latchTag_d;

    logic              rspValid_q, rspValid_d;
    logic [TAG_W-1:0]  rspTag_q, rspTag_d;
    logic [DATA_W-1:0] rspData1_q, rspData1_d;
    logic [DATA_W-1:0] rspData2_q, rspData2_d;
    logic [DATA_W-1:0] rspData3_q, rspData3_d;

    logic              reqReady;
    logic              rdEn;
    logic [WID_W-1:0]  rdWid;
    logic [NR_W-1:0]   rdAddr0;
    logic [NR_W-1:0]   rdAddr1;
    logic [DATA_W-1:0] opData0;
    logic [DATA_W-1:0] opData1;

`ifdef GPR_SCHED_R0_ZERO_EN
    logic [NR_W-1:0]   latchRs1_q, latchRs1_d;
    logic [NR_W-1:0]   latchRs2_q, latchRs2_d;
    logic [NR_W-1:0]   opIdx0;
`endif

    always_comb begin
        state_d    = state_q;
        latchWid_d = latchWid_q;
        latchRs3_d = latchRs3_q;
        latchTag_d = latchTag_q;
`ifdef GPR_SCHED_R0_ZERO_EN
        latchRs1_d = latchRs1_q;
        latchRs2_d = latchRs2_q;
`endif
        reqReady   = 1'b0;
        rdEn       = 1'b0;
        rdWid      = '0;
        rdAddr0    = '0;
        rdAddr1    = '0;

        case (state_q)
            IDLE: begin
                // Admit only when the output register will be free by the capture cycle.
                reqReady = !rspValid_q || bus.rsp_ready;
                if (bus.req_valid && reqReady) begin
                    rdEn       = 1'b1;
                    rdWid      = bus.req_wid;
                    rdAddr0    = bus.req_rs1;
                    rdAddr1    = bus.req_rs2;
                    latchWid_d = bus.req_wid;
                    latchRs3_d = bus.req_rs3;
                    latchTag_d = bus.req_tag;
`ifdef GPR_SCHED_R0_ZERO_EN
                    latchRs1_d = bus.req_rs1;
                    latchRs2_d = bus.req_rs2;
`endif
                    state_d    = bus.req_use_rs3 ? RD3 : CAP12;
                end
            end
            RD3: begin
                rdEn    = 1'b1;
                rdWid   = latchWid_q;
                rdAddr0 = latchRs3_q;
                rdAddr1 = latchRs3_q;
                state_d = CAP3;
            end
            CAP12:   state_d = IDLE;
            CAP3:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef GPR_SCHED_R0_ZERO_EN
    // Port 0 carries rs1 data except in CAP3, where it carries the rs3 read.
    always_comb begin
        opIdx0  = (state_q == CAP3) ? latchRs3_q : latchRs1_q;
        opData0 = (opIdx0 == '0) ? '0 : bus.gpr_data0;
        opData1 = (latchRs2_q == '0) ? '0 : bus.gpr_data1;
    end
`else
    assign opData0 = bus.gpr_data0;
    assign opData1 = bus.gpr_data1;
`endif

    always_comb begin
        rspValid_d = rspValid_q;
        rspTag_d   = rspTag_q;
        rspData1_d = rspData1_q;
        rspData2_d = rspData2_q;
        rspData3_d = rspData3_q;

        if (rspValid_q && bus.rsp_ready) begin
            rspValid_d = 1'b0;
        end

        case (state_q)
            RD3: begin
                rspData1_d = opData0;
                rspData2_d = opData1;
            end
            CAP12: begin
                rspData1_d = opData0;
                rspData2_d = opData1;
                rspData3_d = '0;
                rspTag_d   = latchTag_q;
                rspValid_d = 1'b1;
            end
            CAP3: begin
                rspData3_d = opData0;
                rspTag_d   = latchTag_q;
                rspValid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            latchWid_q <= '0;
            latchRs3_q <= '0;
            latchTag_q <= '0;
`ifdef GPR_SCHED_R0_ZERO_EN
            latchRs1_q <= '0;
            latchRs2_q <= '0;
`endif
            rspValid_q <= 1'b0;
            rspTag_q   <= '0;
            rspData1_q <= '0;
            rspData2_q <= '0;
            rspData3_q <= '0;
        end else begin
            state_q    <= state_d;
            latchWid_q <= latchWid_d;
            latchRs3_q <= latchRs3_d;
            latchTag_q <= latchTag_d;
`ifdef GPR_SCHED_R0_ZERO_EN
            latchRs1_q <= latchRs1_d;
            latchRs2_q <= latchRs2_d;
`endif
            rspValid_q <= rspValid_d;
            rspTag_q   <= rspTag_d;
            rspData1_q <= rspData1_d;
            rspData2_q <= rspData2_d;
            rspData3_q <= rspData3_d;
        end
    end

    assign bus.req_ready = reqReady;
    assign bus.gpr_rd_en = rdEn;
    assign bus.gpr_wid   = rdWid;
    assign bus.gpr_addr0 = rdAddr0;
    assign bus.gpr_addr1 = rdAddr1;
    assign bus.rsp_valid = rspValid_q;
    assign bus.rsp_tag   = rspTag_q;
    assign bus.rsp_data1 = rspData1_q;
    assign bus.rsp_data2 = rspData2_q;
    assign bus.rsp_data3 = rspData3_q;

endmodule

// File: tb/tb_gpr_read_sched.sv
// Directed testbench for gpr_read_sched with a behavioural two-port register file.
// Expected values for register-0 reads follow GPR_SCHED_R0_ZERO_EN.
module tb_gpr_read_sched;

    logic clk = 1'b0;
    logic reset;
    int   vecCount  = 0;
    int   missCount = 0;

    logic [127:0] rfMem [4][32];

    gpr_read_sched_if bus ();

    gpr_read_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Register file: data valid one cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        if (bus.gpr_rd_en) begin
            bus.gpr_data0 <= rfMem[bus.gpr_wid][bus.gpr_addr0];
            bus.gpr_data1 <= rfMem[bus.gpr_wid][bus.gpr_addr1];
        end else begin
            bus.gpr_data0 <= {$urandom(), $urandom(), $urandom(), $urandom()};
            bus.gpr_data1 <= {$urandom(), $urandom(), $urandom(), $urandom()};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.req_valid   = 1'b0;
        bus.req_wid     = '0;
        bus.req_rs1     = '0;
        bus.req_rs2     = '0;
        bus.req_rs3     = '0;
        bus.req_use_rs3 = 1'b0;
        bus.req_tag     = '0;
        bus.rsp_ready   = 1'b1;
    endtask

    task automatic setReq(input logic [1:0] wid, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rs3, input logic useRs3, input logic [7:0] tag);
        bus.req_valid   = 1'b1;
        bus.req_wid     = wid;
        bus.req_rs1     = rs1;
        bus.req_rs2     = rs2;
        bus.req_rs3     = rs3;
        bus.req_use_rs3 = useRs3;
        bus.req_tag     = tag;
    endtask

    task automatic test_reset();
        idleInputs();
        bus.rsp_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vecCount++; if (bus.rsp_valid !== 1'b0) begin missCount++; $display("[TB] FAIL reset_rsp_valid got %0b want 0", bus.rsp_valid); end
        vecCount++; if (bus.req_ready !== 1'b1) begin missCount++; $display("[TB] FAIL reset_req_ready got %0b want 1", bus.req_ready); end
        vecCount++; if (bus.gpr_rd_en !== 1'b0) begin missCount++; $display("[TB] FAIL reset_rd_en got %0b want 0", bus.gpr_rd_en); end
        vecCount++; if (bus.rsp_tag !== 8'h00) begin missCount++; $display("[TB] FAIL reset_tag got %h want 00", bus.rsp_tag); end
        vecCount++; if (bus.rsp_data1 !== 128'h0) begin missCount++; $display("[TB] FAIL reset_data1 got %h want 0", bus.rsp_data1); end
        reset = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
    endtask

    task automatic test_three_op();
        setReq(2'd1, 5'd1, 5'd2, 5'd3, 1'b1, 8'h22);
        #1;
        vecCount++; if (bus.gpr_rd_en !== 1'b1 || bus.gpr_addr0 !== 5'd1 || bus.gpr_addr1 !== 5'd2 || bus.gpr_wid !== 2'd1)
            begin missCount++; $display("[TB] FAIL op3_read12 got en=%0b a0=%0d a1=%0d w=%0d want 1/1/2/1", bus.gpr_rd_en, bus.gpr_addr0, bus.gpr_addr1, bus.gpr_wid); end
        tick();
        bus.req_valid = 1'b0;
        #1;
        vecCount++; if (bus.gpr_rd_en !== 1'b1 || bus.gpr_addr0 !== 5'd3 || bus.gpr_addr1 !== 5'd3 || bus.gpr_wid !== 2'd1)
            begin missCount++; $display("[TB] FAIL op3_read3 got en=%0b a0=%0d a1=%0d w=%0d want 1/3/3/1", bus.gpr_rd_en, bus.gpr_addr0, bus.gpr_addr1, bus.gpr_wid); end
        vecCount++; if (bus.req_ready !== 1'b0) begin missCount++; $display("[TB] FAIL op3_rd3_ready got %0b want 0", bus.req_ready); end
        tick();
        vecCount++; if (bus.rsp_valid !== 1'b0 || bus.gpr_rd_en !== 1'b0)
            begin missCount++; $display("[TB] FAIL op3_n2 got valid=%0b en=%0b want 0/0", bus.rsp_valid, bus.gpr_rd_en); end
        tick();
        vecCount++; if (bus.rsp_valid !== 1'b1) begin missCount++; $display("[TB] FAIL op3_valid got %0b want 1", bus.rsp_valid); end
        vecCount++; if (bus.rsp_data1 !== rfMem[1][1]) begin missCount++; $display("[TB] FAIL op3_data1 got %h want %h", bus.rsp_data1, rfMem[1][1]); end
        vecCount++; if (bus.rsp_data2 !== rfMem[1][2]) begin missCount++; $display("[TB] FAIL op3_data2 got %h want %h", bus.rsp_data2, rfMem[1][2]); end
        vecCount++; if (bus.rsp_data3 !== rfMem[1][3]) begin missCount++; $display("[TB] FAIL op3_data3 got %h want %h", bus.rsp_data3, rfMem[1][3]); end
        vecCount++; if (bus.rsp_tag !== 8'h22) begin missCount++; $display("[TB] FAIL op3_tag got %h want 22", bus.rsp_tag); end
        tick();
    endtask

    task automatic test_two_op();
        rfMem[2][5] = {4{32'hA5A5A5A5}};
        rfMem[2][7] = {4{32'h5A5A5A5A}};
        setReq(2'd2, 5'd5, 5'd7, 5'd0, 1'b0, 8'h11);
        #1;
        vecCount++; if (bus.req_ready !== 1'b1) begin missCount++; $display("[TB] FAIL op2_ready got %0b want 1", bus.req_ready); end
        vecCount++; if (bus.gpr_rd_en !== 1'b1 || bus.gpr_addr0 !== 5'd5 || bus.gpr_addr1 !== 5'd7 || bus.gpr_wid !== 2'd2)
            begin missCount++; $display("[TB] FAIL op2_read got en=%0b a0=%0d a1=%0d w=%0d want 1/5/7/2", bus.gpr_rd_en, bus.gpr_addr0, bus.gpr_addr1, bus.gpr_wid); end
        tick();
        bus.req_valid = 1'b0;
        #1;
        vecCount++; if (bus.rsp_valid !== 1'b0 || bus.gpr_rd_en !== 1'b0)
            begin missCount++; $display("[TB] FAIL op2_n1 got valid=%0b en=%0b want 0/0", bus.rsp_valid, bus.gpr_rd_en); end
        tick();
        vecCount++; if (bus.rsp_valid !== 1'b1) begin missCount++; $display("[TB] FAIL op2_valid got %0b want 1", bus.rsp_valid); end
        vecCount++; if (bus.rsp_data1 !== {4{32'hA5A5A5A5}}) begin missCount++; $display("[TB] FAIL op2_data1 got %h want a5..", bus.rsp_data1); end
        vecCount++; if (bus.rsp_data2 !== {4{32'h5A5A5A5A}}) begin missCount++; $display("[TB] FAIL op2_data2 got %h want 5a..", bus.rsp_data2); end
        vecCount++; if (bus.rsp_data3 !== 128'h0) begin missCount++; $display("[TB] FAIL op2_data3 got %h want 0", bus.rsp_data3); end
        vecCount++; if (bus.rsp_tag !== 8'h11) begin missCount++; $display("[TB] FAIL op2_tag got %h want 11", bus.rsp_tag); end
        tick();
        vecCount++; if (bus.rsp_valid !== 1'b0) begin missCount++; $display("[TB] FAIL op2_consumed got %0b want 0", bus.rsp_valid); end
    endtask

    task automatic test_backpressure();
        bus.rsp_ready = 1'b0;
        setReq(2'd3, 5'd9, 5'd10, 5'd0, 1'b0, 8'h30);
        #1;
        vecCount++; if (bus.req_ready !== 1'b1) begin missCount++; $display("[TB] FAIL bp_first_ready got %0b want 1", bus.req_ready); end
        tick();
        setReq(2'd0, 5'd12, 5'd13, 5'd0, 1'b0, 8'h31);
        tick();
        for (int i = 0; i < 5; i++) begin
            vecCount++; if (bus.req_ready !== 1'b0 || bus.gpr_rd_en !== 1'b0)
                begin missCount++; $display("[TB] FAIL bp_stall%0d got ready=%0b en=%0b want 0/0", i, bus.req_ready, bus.gpr_rd_en); end
            vecCount++; if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 8'h30 || bus.rsp_data1 !== rfMem[3][9] || bus.rsp_data2 !== rfMem[3][10])
                begin missCount++; $display("[TB] FAIL bp_hold%0d got valid=%0b tag=%h want 1/30", i, bus.rsp_valid, bus.rsp_tag); end
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        vecCount++; if (bus.req_ready !== 1'b1 || bus.gpr_rd_en !== 1'b1 || bus.gpr_addr0 !== 5'd12 || bus.gpr_addr1 !== 5'd13)
            begin missCount++; $display("[TB] FAIL bp_release got ready=%0b en=%0b a0=%0d want 1/1/12", bus.req_ready, bus.gpr_rd_en, bus.gpr_addr0); end
        tick();
        bus.req_valid = 1'b0;
        #1;
        vecCount++; if (bus.rsp_valid !== 1'b0) begin missCount++; $display("[TB] FAIL bp_drained got %0b want 0", bus.rsp_valid); end
        tick();
        vecCount++; if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 8'h31 || bus.rsp_data1 !== rfMem[0][12] || bus.rsp_data2 !== rfMem[0][13])
            begin missCount++; $display("[TB] FAIL bp_second got valid=%0b tag=%h want 1/31", bus.rsp_valid, bus.rsp_tag); end
        tick();
    endtask

    task automatic test_streaming();
        int fireIdx = 0;
        int rspIdx  = 0;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (fireIdx < 4) setReq(2'(fireIdx), 5'(fireIdx + 4), 5'(fireIdx + 8), 5'd0, 1'b0, 8'(fireIdx));
            else bus.req_valid = 1'b0;
            #1;
            if (bus.req_valid && bus.req_ready) begin
                vecCount++; if (c != 2 * fireIdx) begin missCount++; $display("[TB] FAIL stream_fire%0d got cycle %0d want %0d", fireIdx, c, 2 * fireIdx); end
                fireIdx++;
            end
            if (bus.rsp_valid) begin
                vecCount++; if (c != 2 * rspIdx + 2 || bus.rsp_tag !== 8'(rspIdx) || bus.rsp_data1 !== rfMem[rspIdx][rspIdx + 4] || bus.rsp_data2 !== rfMem[rspIdx][rspIdx + 8])
                    begin missCount++; $display("[TB] FAIL stream_rsp%0d got cycle %0d tag %h want cycle %0d tag %0d", rspIdx, c, bus.rsp_tag, 2 * rspIdx + 2, rspIdx); end
                rspIdx++;
            end
            tick();
        end
        vecCount++; if (fireIdx != 4 || rspIdx != 4) begin missCount++; $display("[TB] FAIL stream_count got fires=%0d rsps=%0d want 4/4", fireIdx, rspIdx); end
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        setReq(2'd2, 5'd4, 5'd5, 5'd6, 1'b1, 8'h44);
        tick();
        bus.req_valid = 1'b0;
        #1;
        vecCount++; if (bus.gpr_rd_en !== 1'b1 || bus.gpr_addr0 !== 5'd6) begin missCount++; $display("[TB] FAIL rmid_in_rd3 got en=%0b a0=%0d want 1/6", bus.gpr_rd_en, bus.gpr_addr0); end
        reset = 1'b1;
        #1;
        vecCount++; if (bus.rsp_valid !== 1'b0 || bus.gpr_rd_en !== 1'b0 || bus.req_ready !== 1'b1)
            begin missCount++; $display("[TB] FAIL rmid_idle got valid=%0b en=%0b ready=%0b want 0/0/1", bus.rsp_valid, bus.gpr_rd_en, bus.req_ready); end
        vecCount++; if (bus.rsp_tag !== 8'h00 || bus.rsp_data1 !== 128'h0)
            begin missCount++; $display("[TB] FAIL rmid_cleared got tag=%h data1=%h want 0/0", bus.rsp_tag, bus.rsp_data1); end
        @(posedge clk);
        #3;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            vecCount++; if (bus.rsp_valid !== 1'b0) begin missCount++; $display("[TB] FAIL rmid_norsp%0d got %0b want 0", i, bus.rsp_valid); end
        end
        setReq(2'd2, 5'd4, 5'd5, 5'd0, 1'b0, 8'h45);
        tick();
        bus.req_valid = 1'b0;
        tick();
        vecCount++; if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 8'h45 || bus.rsp_data1 !== rfMem[2][4] || bus.rsp_data2 !== rfMem[2][5])
            begin missCount++; $display("[TB] FAIL rmid_after got valid=%0b tag=%h want 1/45", bus.rsp_valid, bus.rsp_tag); end
        tick();
    endtask

    task automatic test_r0();
        logic [127:0] expData1;
        rfMem[0][0] = '1;
`ifdef GPR_SCHED_R0_ZERO_EN
        expData1 = '0;
`else
        expData1 = '1;
`endif
        setReq(2'd0, 5'd0, 5'd6, 5'd0, 1'b0, 8'h50);
        tick();
        bus.req_valid = 1'b0;
        tick();
        vecCount++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data1 !== expData1)
            begin missCount++; $display("[TB] FAIL r0_data1 got valid=%0b data1=%h want 1/%h", bus.rsp_valid, bus.rsp_data1, expData1); end
        vecCount++; if (bus.rsp_data2 !== rfMem[0][6]) begin missCount++; $display("[TB] FAIL r0_data2 got %h want %h", bus.rsp_data2, rfMem[0][6]); end
        tick();
    endtask

    initial begin
        for (int w = 0; w < 4; w++) begin
            for (int r = 0; r < 32; r++) begin
                rfMem[w][r] = {8'(w + 1), 8'(r), 16'h1111, 8'(w + 1), 8'(r), 16'h2222,
                               8'(w + 1), 8'(r), 16'h3333, 8'(w + 1), 8'(r), 16'h4444};
            end
        end
        reset = 1'b1;
        idleInputs();
        test_reset();
        test_three_op();
        test_two_op();
        test_backpressure();
        test_streaming();
        test_reset_mid();
        test_r0();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
